// File: rtl/nios2vga_sysid_ext.sv
// System-ID / housekeeping Avalon-MM slave: ID, timestamp, scratch, 64-bit cycle
// counter with atomic high-word snapshot, seconds counter and control word.
module nios2vga_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID     = 32'h52D6_0B08,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    localparam logic [2:0]  A_ID      = 3'd0;
    localparam logic [2:0]  A_TSTAMP  = 3'd1;
    localparam logic [2:0]  A_SCRATCH = 3'd2;
    localparam logic [2:0]  A_CYC_LO  = 3'd3;
    localparam logic [2:0]  A_CYC_HI  = 3'd4;
    localparam logic [2:0]  A_SECONDS = 3'd5;
    localparam logic [2:0]  A_CONTROL = 3'd6;
    localparam logic [2:0]  A_FREQ    = 3'd7;
    localparam logic [31:0] FREQ_W    = 32'(CLK_FREQ_HZ);
    localparam logic [31:0] PRESC_MAX = 32'(CLK_FREQ_HZ - 1);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] scratch_q, scratch_d;
    logic [63:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] sec_q, sec_d;
    logic        freeze_q, freeze_d;
    logic        clr_q, clr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic [31:0] rd_mux;
    logic        wr_ctrl;

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            A_ID:      rd_mux = SYSTEM_ID;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_SCRATCH: rd_mux = scratch_q;
            A_CYC_LO:  rd_mux = cyc_q[31:0];
            A_CYC_HI:  rd_mux = snap_q;
            A_SECONDS: rd_mux = sec_q;
            A_CONTROL: rd_mux = {30'd0, freeze_q, 1'b0};
            A_FREQ:    rd_mux = FREQ_W;
            default:   rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        rdata_d   = read ? rd_mux : rdata_q;
        rvld_d    = read;
        scratch_d = scratch_q;
        if (write && address == A_SCRATCH) begin
            scratch_d = byte_merge(scratch_q, writedata, byteenable);
        end
        // Only lane 0 carries the live control bits; the clear is a one-cycle pending pulse.
        wr_ctrl  = write && (address == A_CONTROL) && byteenable[0];
        freeze_d = wr_ctrl ? writedata[1] : freeze_q;
        clr_d    = wr_ctrl && writedata[0];

        cyc_d   = cyc_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        snap_d  = snap_q;
        if (read && address == A_CYC_LO) begin
            snap_d = cyc_q[63:32];
        end
        // Clear overrides both the snapshot load and counting, even while frozen.
        if (clr_q) begin
            cyc_d   = 64'd0;
            presc_d = 32'd0;
            sec_d   = 32'd0;
            snap_d  = 32'd0;
        end else if (!freeze_q) begin
            cyc_d = cyc_q + 64'd1;
            if (presc_q >= PRESC_MAX) begin
                presc_d = 32'd0;
                sec_d   = sec_q + 32'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= SCRATCH_RESET;
            cyc_q     <= 64'd0;
            snap_q    <= 32'd0;
            presc_q   <= 32'd0;
            sec_q     <= 32'd0;
            freeze_q  <= 1'b0;
            clr_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rvld_q    <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            freeze_q  <= freeze_d;
            clr_q     <= clr_d;
            rdata_q   <= rdata_d;
            rvld_q    <= rvld_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvld_q;
endmodule

// File: tb/tb_nios2vga_sysid_ext.sv
// Bench for nios2vga_sysid_ext: a default instance and a CLK_FREQ_HZ=4 instance share
// one bus; expected read data is queued per instance and compared when valid appears.
module tb_nios2vga_sysid_ext;
    localparam logic [31:0] ID = 32'h52D6_0B08;

    typedef struct packed {
        logic        chk;
        logic [2:0]  addr;
        logic [31:0] v;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata_m, rdata_4;
    logic        rvld_m, rvld_4;

    exp_t q_m[$];
    exp_t q_4[$];
    int   total = 0;
    int   bad   = 0;

    nios2vga_sysid_ext dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata_m), .readdatavalid(rvld_m)
    );

    nios2vga_sysid_ext #(.CLK_FREQ_HZ(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata_4), .readdatavalid(rvld_4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: pop one expectation per valid cycle on each instance.
    always @(negedge clock) begin
        exp_t e;
        if (rvld_m) begin
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid_main got=1 required=0");
            end else begin
                e = q_m.pop_front();
                if (e.chk) begin
                    total++;
                    if (rdata_m !== e.v) begin
                        bad++;
                        $display("FAIL rd_main addr=%0d got=%h required=%h", e.addr, rdata_m, e.v);
                    end
                end
            end
        end
        if (rvld_4) begin
            if (q_4.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid_f4 got=1 required=0");
            end else begin
                e = q_4.pop_front();
                if (e.chk) begin
                    total++;
                    if (rdata_4 !== e.v) begin
                        bad++;
                        $display("FAIL rd_f4 addr=%0d got=%h required=%h", e.addr, rdata_4, e.v);
                    end
                end
            end
        end
    end

    task automatic do_read(input logic [2:0] a, input logic cm, input logic [31:0] em,
                           input logic c4, input logic [31:0] e4);
        exp_t e;
        read = 1'b1; write = 1'b0; address = a;
        e.chk = cm; e.addr = a; e.v = em; q_m.push_back(e);
        e.chk = c4; e.addr = a; e.v = e4; q_4.push_back(e);
        @(negedge clock);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        read = 1'b0; write = 1'b1; address = a; writedata = d; byteenable = be;
        @(negedge clock);
    endtask

    task automatic do_rw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] em, input logic [31:0] e4);
        exp_t e;
        read = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
        e.chk = 1'b1; e.addr = a; e.v = em; q_m.push_back(e);
        e.chk = 1'b1; e.addr = a; e.v = e4; q_4.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        read = 1'b0; write = 1'b0; byteenable = 4'h0;
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        idle(0);
        while ((q_m.size() != 0 || q_4.size() != 0) && n < 10) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++;
        if (q_m.size() != 0 || q_4.size() != 0) begin
            bad++;
            $display("FAIL drain pending main=%0d f4=%0d required=0", q_m.size(), q_4.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; read = 1'b0; write = 1'b0; address = 3'd0;
        writedata = 32'd0; byteenable = 4'h0;
        idle(2);
        total++;
        if (rvld_m !== 1'b0 || rdata_m !== 32'd0 || rvld_4 !== 1'b0 || rdata_4 !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h required=0/0", rvld_m, rdata_m);
        end
        reset_n = 1'b1;
        do_read(3'd0, 1'b1, ID, 1'b1, ID);
        total++;
        if (rvld_m !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got=%b required=1", rvld_m); end
        do_read(3'd1, 1'b1, 32'h0, 1'b1, 32'h0);
        total++;
        if (rvld_m !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b required=1", rvld_m); end
        do_read(3'd7, 1'b1, 32'd50_000_000, 1'b1, 32'd4);
        total++;
        if (rvld_m !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b required=1", rvld_m); end
        idle(1);
        total++;
        if (rvld_m !== 1'b0) begin bad++; $display("FAIL valid_drop got=%b required=0", rvld_m); end
        drain();
    endtask

    task automatic test_seconds();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(13);
        do_read(3'd5, 1'b1, 32'd0, 1'b1, 32'd3);
        do_write(3'd6, 32'd2, 4'hF);
        idle(20);
        do_read(3'd5, 1'b1, 32'd0, 1'b1, 32'd3);
        do_read(3'd3, 1'b1, 32'd15, 1'b1, 32'd15);
        do_read(3'd6, 1'b1, 32'd2, 1'b1, 32'd2);
        drain();
    endtask

    task automatic test_scratch();
        do_read(3'd2, 1'b1, 32'h0, 1'b1, 32'h0);
        do_write(3'd2, 32'hDEAD_BEEF, 4'hF);
        do_write(3'd2, 32'h0000_1234, 4'b0011);
        do_read(3'd2, 1'b1, 32'hDEAD_1234, 1'b1, 32'hDEAD_1234);
        do_write(3'd2, 32'hFFFF_FFFF, 4'h0);
        do_read(3'd2, 1'b1, 32'hDEAD_1234, 1'b1, 32'hDEAD_1234);
        do_write(3'd0, 32'h0, 4'hF);
        do_write(3'd7, 32'h0, 4'hF);
        do_read(3'd0, 1'b1, ID, 1'b1, ID);
        do_read(3'd7, 1'b1, 32'd50_000_000, 1'b1, 32'd4);
        do_rw(3'd2, 32'hA5A5_A5A5, 4'hF, 32'hDEAD_1234, 32'hDEAD_1234);
        do_read(3'd2, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5);
        do_write(3'd6, 32'hFFFF_FFFE, 4'hF);
        do_read(3'd6, 1'b1, 32'd2, 1'b1, 32'd2);
        drain();
    endtask

    task automatic test_snapshot();
        force dut.cyc_q = 64'h0000_0001_FFFF_FFFF;
        do_read(3'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd15);
        do_read(3'd4, 1'b1, 32'h1, 1'b1, 32'h0);
        idle(1);
        release dut.cyc_q;
        idle(10);
        do_read(3'd4, 1'b1, 32'h1, 1'b1, 32'h0);
        drain();
    endtask

    task automatic test_clear();
        do_write(3'd6, 32'd3, 4'hF);
        idle(1);
        do_read(3'd3, 1'b1, 32'd0, 1'b1, 32'd0);
        do_read(3'd4, 1'b1, 32'd0, 1'b1, 32'd0);
        do_read(3'd5, 1'b1, 32'd0, 1'b1, 32'd0);
        do_read(3'd6, 1'b1, 32'd2, 1'b1, 32'd2);
        do_write(3'd6, 32'd0, 4'hF);
        idle(5);
        do_read(3'd3, 1'b1, 32'd5, 1'b1, 32'd5);
    endtask

    task automatic test_clear_read();
        do_write(3'd6, 32'd1, 4'hF);
        force dut.cyc_q = 64'h0000_0005_0000_0010;
        do_read(3'd3, 1'b1, 32'h10, 1'b1, 32'd7);
        do_read(3'd4, 1'b1, 32'd0, 1'b1, 32'd0);
        release dut.cyc_q;
        do_read(3'd3, 1'b0, 32'd0, 1'b1, 32'd1);
        do_read(3'd6, 1'b1, 32'd0, 1'b1, 32'd0);
        drain();
    endtask

    task automatic test_reset_mid_read();
        do_write(3'd2, 32'h1357_9BDF, 4'hF);
        idle(1);
        read = 1'b1; address = 3'd0;
        @(posedge clock);
        #1;
        total++;
        if (rvld_m !== 1'b1 || rdata_m !== ID) begin
            bad++;
            $display("FAIL midread_valid got=%b/%h required=1/%h", rvld_m, rdata_m, ID);
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (rvld_m !== 1'b0 || rdata_m !== 32'd0 || rvld_4 !== 1'b0 || rdata_4 !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got=%b/%h required=0/0", rvld_m, rdata_m);
        end
        @(negedge clock);
        idle(1);
        reset_n = 1'b1;
        do_read(3'd2, 1'b1, 32'h0, 1'b1, 32'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_seconds();
        test_scratch();
        test_snapshot();
        test_clear();
        test_clear_read();
        test_reset_mid_read();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
